horner_mac_scheduler: RTL and testbench
=======================================

Name: horner_mac_scheduler

Overview:
- Evaluates y = ((A·x + B)·x + C)·x + D for up to NREQ AXI-Stream requesters, using one shared external IEEE-754 double multiply-add unit (res = a·x + c).
- Round-robin arbitration picks one requester; the block then runs the three Horner steps through the shared unit and returns the result on a single output stream tagged with the requester id.
- Sits between the per-channel sample streams and the MAC datapath, replacing three dedicated stages.

Parameters:
- NREQ, 4, number of requesters (2..8).
- A, 1.0, real, cubic coefficient.
- B, 0.0, real, quadratic coefficient.
- C, 0.0, real, linear coefficient.
- D, 0.0, real, constant coefficient.
- MAC_TIMEOUT, 64, max cycles to wait for mac_res_valid per step.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_tvalid  in  NREQ  per-requester valid.
- s_tready  out  NREQ  per-requester ready.
- s_tdata  in  NREQ*64  per-requester x, IEEE-754 double; requester i uses bits [64i+63:64i].
- s_tlast  in  NREQ  per-requester last.
- mac_valid  out  1  one-cycle operation strobe.
- mac_a  out  64  multiplicand operand (double).
- mac_x  out  64  multiplier operand (double).
- mac_c  out  64  addend operand (double).
- mac_res_valid  in  1  result strobe from the MAC.
- mac_res  in  64  MAC result (double).
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  64  y (double).
- m_tlast  out  1  copy of the accepted sample's s_tlast.
- m_tid  out  max(1,$clog2(NREQ))  index of the requester that was served.
- err  out  1  sticky MAC-timeout flag.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; step=0; RR pointer=NREQ-1, so requester 0 has first priority.
  - All registered outputs are 0 (m_tvalid, m_tdata, m_tlast, m_tid, mac_valid, mac_a/x/c, err).
  - s_tready=0 while rst is high.
  - Reset mid-operation abandons the sample; no output is produced for it.
- States:
  - IDLE → ISSUE → WAIT → (ISSUE | OUT) → IDLE.
- IDLE:
  - grant = first index with s_tvalid set, searching from ptr+1 modulo NREQ.
  - s_tready is combinational: only s_tready[grant] is high, and only when in IDLE with some s_tvalid set.
  - On handshake: latch x, tlast and id=grant; set ptr=grant, step=0; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - Assert mac_valid for exactly one cycle (registered).
  - Operands by step:
    - step 0: mac_a=bits(A), mac_x=x, mac_c=bits(B).
    - step 1: mac_a=acc, mac_x=x, mac_c=bits(C).
    - step 2: mac_a=acc, mac_x=x, mac_c=bits(D).
  - Go to WAIT.
  - Operand outputs hold their value until the next ISSUE.
- WAIT:
  - On mac_res_valid, acc=mac_res.
    - If step<2: step++ and go to ISSUE.
    - Else: load m_tdata=mac_res, m_tlast, m_tid; go to OUT.
  - mac_res_valid outside WAIT is ignored.
  - A timeout counter counts WAIT cycles. When it reaches MAC_TIMEOUT without a result:
    - set err=1 (sticky until reset);
    - m_tdata=64'h7FF8_0000_0000_0000 (quiet NaN);
    - go to OUT.
- OUT:
  - m_tvalid=1.
  - m_tdata, m_tlast and m_tid are stable until m_tready.
  - On m_tvalid&m_tready: m_tvalid=0 next cycle; go to IDLE.
  - No new input is accepted while in OUT (s_tready=0).
- Latency:
  - With a MAC of fixed latency L (mac_res_valid L cycles after mac_valid), m_tvalid rises 3·(L+1)+1 cycles after the input handshake cycle.
  - The next input can be accepted 1 cycle after the output handshake.
- Fairness:
  - A requester holding s_tvalid is served within NREQ transactions.
  - Requester inputs do not need to stay stable while not granted.
- Arithmetic: the block performs none; coefficients are converted once via $realtobits.
- Protocol checks (simulation only): error on
  - m_tvalid falling before handshake;
  - m_tdata changing during backpressure;
  - s_tlast set without s_tvalid on the granted requester.

Test Plan:
- Basic evaluation:
  - Setup: A=1,B=2,C=3,D=4; MAC model L=2; requester 0 sends x=2.0 (64'h4000000000000000), tlast=1.
  - Expect: m_tdata=64'h403A000000000000 (26.0), m_tid=0, m_tlast=1.
  - Expect: m_tvalid rises 10 cycles after the input handshake.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, each with a distinct x.
  - Expect: m_tid sequence 0,1,2,3,0; each result matches its own x.
- Backpressure:
  - Stimulus: m_tready=0 for 20 cycles with a result pending.
  - Expect: m_tvalid stays high; m_tdata/m_tid/m_tlast stable; all s_tready=0; the result transfers on the first m_tready=1.
- MAC timeout:
  - Setup: MAC model never answers step 1; MAC_TIMEOUT=64.
  - Expect: after 64 WAIT cycles, err=1 and m_tdata=64'h7FF8000000000000.
  - Expect: the next sample with a working MAC completes normally; err stays 1.
- Reset mid-step:
  - Stimulus: assert rst asynchronously while in WAIT of step 1.
  - Expect: all outputs immediately 0, err=0, no stale output after release.
  - Expect: the next grant goes to requester 0.
- Spurious strobe:
  - Stimulus: mac_res_valid pulses while in IDLE and OUT.
  - Expect: no state change, output unchanged.

Source files
------------

// File: rtl/horner_mac_scheduler.sv
// ---------------------------------------------------------------------------
// horner_mac_scheduler
//
// Evaluates y = ((A*x + B)*x + C)*x + D for NREQ AXI-Stream requesters. The
// block time-shares one external double-precision multiply-add unit
// (res = a*x + c). A round-robin arbiter picks a requester. The block then
// issues the three Horner steps one after another. The result goes out on a
// single output stream tagged with the id of the requester that was served.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_tvalid/s_tready per-requester handshake (s_tready is combinational)
//   s_tdata           NREQ packed doubles; requester i owns [64i+63:64i]
//   s_tlast           per-requester last flag, forwarded to m_tlast
//   mac_valid         one-cycle strobe for the MAC, with operands
//                     mac_a, mac_x, mac_c
//   mac_res_valid     MAC result strobe; accepted only while waiting
//   mac_res           MAC result
//   m_tvalid/m_tready output handshake
//   m_tdata, m_tlast  result (double) and forwarded last flag
//   m_tid             index of the served requester
//   err               sticky flag, set when the MAC fails to answer in time
// ---------------------------------------------------------------------------
module horner_mac_scheduler #(
    parameter int  NREQ        = 4,
    parameter real A           = 1.0,
    parameter real B           = 0.0,
    parameter real C           = 0.0,
    parameter real D           = 0.0,
    parameter int  MAC_TIMEOUT = 64,
    localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      s_tvalid,
    output logic [NREQ-1:0]      s_tready,
    input  logic [NREQ*64-1:0]   s_tdata,
    input  logic [NREQ-1:0]      s_tlast,
    output logic                 mac_valid,
    output logic [63:0]          mac_a,
    output logic [63:0]          mac_x,
    output logic [63:0]          mac_c,
    input  logic                 mac_res_valid,
    input  logic [63:0]          mac_res,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic [63:0]          m_tdata,
    output logic                 m_tlast,
    output logic [IDW-1:0]       m_tid,
    output logic                 err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    // The coefficients are converted once, at elaboration time.
    localparam logic [63:0] A_BITS = $realtobits(A);
    localparam logic [63:0] B_BITS = $realtobits(B);
    localparam logic [63:0] C_BITS = $realtobits(C);
    localparam logic [63:0] D_BITS = $realtobits(D);
    localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;
    localparam int          TW     = $clog2(MAC_TIMEOUT + 1);

    state_t         state_q;
    logic [1:0]     step_q;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] id_q;
    logic [63:0]    x_q;
    logic           tlast_q;
    logic [TW-1:0]  tmo_q;

    logic [IDW-1:0] grant;
    logic [IDW-1:0] cand;
    logic           any_valid;

    // (p + k) mod NREQ for p < NREQ and k <= NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Round-robin search. It starts just after the last requester served.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        grant     = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = wrap_add(ptr_q, i);
            if (!any_valid && s_tvalid[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        s_tready = '0;
        if (!rst && state_q == S_IDLE && any_valid) s_tready[grant] = 1'b1;
    end

    // The MAC operand register mac_a also serves as the Horner accumulator.
    // Every later step is loaded with the previous mac_res directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            step_q    <= 2'd0;
            ptr_q     <= IDW'(NREQ - 1);
            id_q      <= '0;
            x_q       <= '0;
            tlast_q   <= 1'b0;
            tmo_q     <= '0;
            mac_valid <= 1'b0;
            mac_a     <= '0;
            mac_x     <= '0;
            mac_c     <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            m_tid     <= '0;
            err       <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so that every register samples pre-edge values.
            mac_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        x_q       <= s_tdata[64*int'(grant) +: 64];
                        tlast_q   <= s_tlast[grant];
                        id_q      <= grant;
                        ptr_q     <= grant;
                        step_q    <= 2'd0;
                        // The strobe and operands are loaded on entry, so the
                        // strobe is high during the ISSUE cycle itself.
                        mac_valid <= 1'b1;
                        mac_a     <= A_BITS;
                        mac_x     <= s_tdata[64*int'(grant) +: 64];
                        mac_c     <= B_BITS;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_res_valid) begin
                        if (step_q != 2'd2) begin
                            step_q    <= step_q + 2'd1;
                            mac_valid <= 1'b1;
                            mac_a     <= mac_res;
                            mac_x     <= x_q;
                            mac_c     <= (step_q == 2'd0) ? C_BITS : D_BITS;
                            state_q   <= S_ISSUE;
                        end else begin
                            m_tvalid <= 1'b1;
                            m_tdata  <= mac_res;
                            m_tlast  <= tlast_q;
                            m_tid    <= id_q;
                            state_q  <= S_OUT;
                        end
                    end else if (tmo_q == TW'(MAC_TIMEOUT - 1)) begin
                        // The MAC has not answered. Flag it and give up with a quiet NaN.
                        err      <= 1'b1;
                        m_tvalid <= 1'b1;
                        m_tdata  <= QNAN;
                        m_tlast  <= tlast_q;
                        m_tid    <= id_q;
                        state_q  <= S_OUT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_OUT: begin
                    if (m_tready) begin
                        m_tvalid <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Protocol checks for simulation.
    m_tvalid_hold: assert property (@(posedge clk) disable iff (rst)
        (m_tvalid && !m_tready) |=> m_tvalid);
    m_tdata_hold: assert property (@(posedge clk) disable iff (rst)
        (m_tvalid && !m_tready) |=> $stable(m_tdata));
    s_tlast_valid: assert property (@(posedge clk) disable iff (rst)
        (state_q != S_IDLE) |-> !(s_tlast[id_q] && !s_tvalid[id_q]));

endmodule

// File: tb/tb_horner_mac_scheduler.sv
// ---------------------------------------------------------------------------
// tb_horner_mac_scheduler
//
// Directed bench for horner_mac_scheduler with A=1, B=2, C=3, D=4, so
// y = x^3 + 2x^2 + 3x + 4. The bench includes a fixed-latency (L=2) MAC
// model. The model can be told to drop one issue. A separate strobe
// injects spurious results. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_horner_mac_scheduler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   s_tvalid = '0;
    logic [3:0]   s_tlast  = '0;
    logic [255:0] s_tdata  = '0;
    logic         m_tready = 1'b0;
    wire  [3:0]   s_tready;
    wire          mac_valid;
    wire  [63:0]  mac_a, mac_x, mac_c;
    wire          mac_res_valid;
    wire  [63:0]  mac_res;
    wire          m_tvalid;
    wire  [63:0]  m_tdata;
    wire          m_tlast;
    wire  [1:0]   m_tid;
    wire          err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // MAC model: answers L=2 cycles after mac_valid, unless told to drop an issue.
    logic        st1_v = 1'b0, st2_v = 1'b0;
    logic [63:0] st1_d = '0,   st2_d = '0;
    int          issue_cnt = 0;
    int          drop_at   = -1;
    logic        spur_v = 1'b0;
    logic [63:0] spur_d = '0;

    assign mac_res_valid = st2_v | spur_v;
    assign mac_res       = st2_v ? st2_d : spur_d;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        st1_v <= 1'b0;
        if (mac_valid) begin
            issue_cnt <= issue_cnt + 1;
            if (issue_cnt + 1 != drop_at) begin
                st1_v <= 1'b1;
                st1_d <= $realtobits($bitstoreal(mac_a) * $bitstoreal(mac_x) + $bitstoreal(mac_c));
            end
        end
        st2_v <= st1_v;
        st2_d <= st1_d;
    end

    horner_mac_scheduler #(
        .NREQ(4), .A(1.0), .B(2.0), .C(3.0), .D(4.0), .MAC_TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_x(mac_x), .mac_c(mac_c),
        .mac_res_valid(mac_res_valid), .mac_res(mac_res),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tid(m_tid), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a sample and hold it until it is accepted. hs_cyc is the cycle
    // count seen in the handshake cycle. Returns on the next falling edge.
    task automatic send(input int i, input logic [63:0] x, input logic last, output int hs_cyc);
        int n = 0;
        s_tvalid[i] = 1'b1;
        s_tdata[64*i +: 64] = x;
        s_tlast[i] = last;
        #1;
        while (!s_tready[i] && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("handshake_r%0d", i), 64'(s_tready[i]), 64'd1);
        hs_cyc = cyc;
        @(negedge clk);
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!m_tvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_seen"}, 64'(m_tvalid), 64'd1);
    endtask

    task automatic collect(input string tag, input logic [63:0] exp_data,
                           input logic [1:0] exp_id, input logic exp_last);
        wait_out(tag);
        check({tag, "_data"}, m_tdata, exp_data);
        check({tag, "_tid"},  64'(m_tid), 64'(exp_id));
        check({tag, "_last"}, 64'(m_tlast), 64'(exp_last));
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
    endtask

    // Wait for the k-th mac_valid, counting from the current falling edge.
    task automatic wait_issue(input int k, output int at);
        int seen = 0;
        int n = 0;
        at = 0;
        while (seen < k && n < 500) begin
            if (mac_valid) begin
                seen++;
                if (seen == k) at = cyc;
            end
            if (seen < k) begin
                @(negedge clk);
                n++;
            end
        end
        check("issue_seen", 64'(seen), 64'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hs, t0, t1, bad;
        logic [63:0] snap;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", m_tdata, 64'd0);
        check("rst_mac_valid", 64'(mac_valid), 64'd0);
        check("rst_mac_a", mac_a, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic evaluation: x=2 gives 26.
        send(0, 64'h4000_0000_0000_0000, 1'b1, hs);
        check("basic_mac_a", mac_a, 64'h3FF0_0000_0000_0000);
        check("basic_mac_x", mac_x, 64'h4000_0000_0000_0000);
        check("basic_mac_c", mac_c, 64'h4000_0000_0000_0000);
        wait_out("basic");
        check("basic_latency", 64'(cyc - hs), 64'd10);
        collect("basic", 64'h403A_0000_0000_0000, 2'd0, 1'b1);

        // Spurious result strobe while idle.
        spur_d = 64'hDEAD_BEEF_0000_0001;
        spur_v = 1'b1;
        repeat (2) @(negedge clk);
        spur_v = 1'b0;
        @(negedge clk);
        check("spur_idle_valid", 64'(m_tvalid), 64'd0);
        check("spur_idle_data", m_tdata, 64'h403A_0000_0000_0000);
        check("spur_idle_mac", 64'(mac_valid), 64'd0);

        // Backpressure: requester 1, x=3 gives 58. Requester 2 waits meanwhile.
        send(1, 64'h4008_0000_0000_0000, 1'b0, hs);
        wait_out("bp");
        snap = m_tdata;
        s_tvalid[2] = 1'b1;
        s_tdata[128 +: 64] = 64'h0;
        s_tlast[2] = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            spur_v = (k == 5 || k == 12);
            @(negedge clk);
            if (!m_tvalid || m_tdata !== snap || m_tid !== 2'd1 || m_tlast !== 1'b0 || s_tready !== 4'b0)
                bad++;
        end
        spur_v = 1'b0;
        check("bp_stable_cycles_bad", 64'(bad), 64'd0);
        check("bp_data", m_tdata, 64'h404D_0000_0000_0000);
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
        check("bp_transfer", 64'(m_tvalid), 64'd0);
        check("bp_next_ready", 64'(s_tready), 64'b0100);
        send(2, 64'h0, 1'b1, hs);
        collect("bp_r2", 64'h4010_0000_0000_0000, 2'd2, 1'b1);

        // MAC timeout on step 1.
        drop_at = issue_cnt + 2;
        send(1, 64'h3FF0_0000_0000_0000, 1'b0, hs);
        wait_issue(2, t0);
        check("tmo_err_before", 64'(err), 64'd0);
        wait_out("tmo");
        check("tmo_wait_cycles", 64'(cyc - t0), 64'd65);
        check("tmo_err", 64'(err), 64'd1);
        collect("tmo", 64'h7FF8_0000_0000_0000, 2'd1, 1'b0);
        send(3, 64'hBFF0_0000_0000_0000, 1'b1, hs);
        collect("after_tmo", 64'h4000_0000_0000_0000, 2'd3, 1'b1);
        check("err_sticky", 64'(err), 64'd1);

        // Reset in the WAIT state of step 1. The round-robin load is presented meanwhile.
        send(2, 64'h4008_0000_0000_0000, 1'b1, hs);
        wait_issue(2, t0);
        @(negedge clk);
        s_tdata  = {64'hBFF0_0000_0000_0000, 64'h4008_0000_0000_0000,
                    64'h3FF0_0000_0000_0000, 64'h0};
        s_tlast  = 4'b0101;
        s_tvalid = 4'b1111;
        #2 rst = 1'b1;
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_m_tdata", m_tdata, 64'd0);
        check("midrst_mac_valid", 64'(mac_valid), 64'd0);
        check("midrst_mac_x", mac_x, 64'd0);
        check("midrst_mac_c", mac_c, 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_s_tready", 64'(s_tready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t1 = cyc;

        // Round robin with all requesters valid continuously.
        wait_out("rr0");
        check("rr0_latency", 64'(cyc - t1), 64'd10);
        collect("rr0", 64'h4010_0000_0000_0000, 2'd0, 1'b1);
        collect("rr1", 64'h4024_0000_0000_0000, 2'd1, 1'b0);
        collect("rr2", 64'h404D_0000_0000_0000, 2'd2, 1'b1);
        collect("rr3", 64'h4000_0000_0000_0000, 2'd3, 1'b0);
        wait_out("rr4");
        s_tvalid = 4'b0;
        s_tlast  = 4'b0;
        collect("rr4", 64'h4010_0000_0000_0000, 2'd0, 1'b1);
        check("rr_err_clear", 64'(err), 64'd0);

        repeat (5) @(negedge clk);
        check("end_idle", 64'(m_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
